// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the round-robin source-FIFO scheduler.
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BURST = 2'd2
   } state_t;

   localparam int SKID_DEPTH = 2;
   localparam int PERF_W     = 16;

endpackage

// File: rtl/fifo_rr_sched_rr_pick.sv
// Cyclic first-one finder: returns the first asserted req at or after ptr,
// wrapping around, plus a valid flag when any req is set.
module rr_pick #(
   parameter int NSRC = 4,
   parameter int IDW  = $clog2(NSRC)
) (
   input  logic [NSRC-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  gnt_id,
   output logic            valid
);

   logic [IDW-1:0] idx;

   // scan NSRC positions starting at ptr, keep the first hit
   always_comb begin
      gnt_id = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NSRC; i++) begin
         idx = IDW'((int'(ptr) + i) % NSRC);
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            gnt_id = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin burst scheduler: drains NSRC source FIFOs (1-cycle read latency)
// into one sink FIFO, tagging every word with its source ID.
// Optional build macro FIFO_RR_SCHED_PERF_EN adds per-source write counters
// (PERF_CNT output, PERF_CLR input).
//
// state | meaning
// IDLE  | waiting for EN and a non-empty source
// GRANT | one cycle, latches the picked source and clears the burst count
// BURST | popping the granted source while it has data, EN and credit
module fifo_rr_sched #(
   parameter int DWIDTH = 32,
   parameter int NSRC   = 4,
   parameter int BURST  = 8,
   parameter int IDW    = $clog2(NSRC)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   EN,
   input  logic [NSRC-1:0]        SRC_EMPTY,
   output logic [NSRC-1:0]        SRC_RD_EN,
   input  logic [NSRC*DWIDTH-1:0] SRC_DOUT,
   input  logic                   SNK_FULL,
   output logic                   SNK_WR_EN,
   output logic [DWIDTH-1:0]      SNK_DIN,
   output logic [IDW-1:0]         SNK_ID,
   output logic [IDW-1:0]         GNT_ID,
   output logic                   BUSY
`ifdef FIFO_RR_SCHED_PERF_EN
   ,
   input  logic                   PERF_CLR,
   output logic [NSRC*16-1:0]     PERF_CNT
`endif
);

   import fifo_sched_pkg::*;

   localparam int CW = $clog2(BURST + 1);

   state_t            state;
   logic [CW-1:0]     burst_cnt;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    pick_id;
   logic              pick_valid;
   logic              inflight;
   logic [IDW-1:0]    inflight_tag;
   logic [DWIDTH-1:0] skid_data [SKID_DEPTH];
   logic [IDW-1:0]    skid_tag  [SKID_DEPTH];
   logic [1:0]        skid_cnt;
   logic [1:0]        occ_after;
   logic [1:0]        wr_pos;
   logic              credit;
   logic              pop;
   logic              last;
   logic              snk_wr;
   logic [DWIDTH-1:0] cap_data;

   rr_pick #(.NSRC(NSRC), .IDW(IDW)) u_pick (
      .req    (~SRC_EMPTY),
      .ptr    (rr_ptr),
      .gnt_id (pick_id),
      .valid  (pick_valid)
   );

   // credit: a new pop must still find a skid slot when its word lands
   always_comb begin
      snk_wr    = (skid_cnt != 2'd0) && !SNK_FULL;
      occ_after = 2'(inflight) + skid_cnt - 2'(snk_wr);
      credit    = occ_after < 2'd2;
      pop       = (state == fifo_sched_pkg::BURST) && EN && !SRC_EMPTY[GNT_ID] && credit;
      last      = burst_cnt == CW'(BURST - 1);
      wr_pos    = skid_cnt - 2'(snk_wr);
      cap_data  = SRC_DOUT[inflight_tag*DWIDTH +: DWIDTH];
      SRC_RD_EN = '0;
      SRC_RD_EN[GNT_ID] = pop;
      SNK_WR_EN = snk_wr;
      SNK_DIN   = skid_data[0];
      SNK_ID    = skid_tag[0];
      BUSY      = (state != IDLE) || inflight || (skid_cnt != 2'd0);
   end

   // grant FSM, burst counter and round-robin pointer
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         burst_cnt <= '0;
         rr_ptr    <= '0;
         GNT_ID    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (EN && pick_valid) state <= GRANT;
            end
            GRANT: begin
               if (pick_valid) begin
                  GNT_ID    <= pick_id;
                  burst_cnt <= '0;
                  state     <= fifo_sched_pkg::BURST;
               end else begin
                  state <= IDLE;
               end
            end
            fifo_sched_pkg::BURST: begin
               if (pop) burst_cnt <= burst_cnt + 1'b1;
               if ((pop && last) || !EN || SRC_EMPTY[GNT_ID]) begin
                  state  <= IDLE;
                  rr_ptr <= (GNT_ID == IDW'(NSRC - 1)) ? '0 : GNT_ID + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // in-flight tracking and 2-entry skid; head shifts out on sink write,
   // the landing word goes into the first free slot after that shift
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         inflight     <= 1'b0;
         inflight_tag <= '0;
         skid_cnt     <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            skid_data[i] <= '0;
            skid_tag[i]  <= '0;
         end
      end else begin
         inflight     <= pop;
         inflight_tag <= GNT_ID;
         if (snk_wr) begin
            skid_data[0] <= skid_data[1];
            skid_tag[0]  <= skid_tag[1];
         end
         if (inflight) begin
            skid_data[wr_pos[0]] <= cap_data;
            skid_tag[wr_pos[0]]  <= inflight_tag;
         end
         skid_cnt <= skid_cnt + 2'(inflight) - 2'(snk_wr);
      end
   end

`ifdef FIFO_RR_SCHED_PERF_EN
   logic [PERF_W-1:0] perf [NSRC];

   // per-source saturating write counters, clear beats increment
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NSRC; i++) perf[i] <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (PERF_CLR) perf[i] <= '0;
            else if (snk_wr && SNK_ID == IDW'(i) && perf[i] != {PERF_W{1'b1}})
               perf[i] <= perf[i] + 1'b1;
         end
      end
   end

   // flatten counters onto the output bus
   always_comb begin
      PERF_CNT = '0;
      for (int i = 0; i < NSRC; i++) PERF_CNT[i*PERF_W +: PERF_W] = perf[i];
   end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched (NSRC=4, BURST=4, DWIDTH=32).
module tb_fifo_rr_sched;

   localparam int DW = 32;
   localparam int NS = 4;
   localparam int BL = 4;
   localparam int IW = 2;

   logic            CLK, RST, EN, SNK_FULL, SNK_WR_EN, BUSY;
   logic [NS-1:0]   SRC_EMPTY, SRC_RD_EN;
   logic [NS*DW-1:0] SRC_DOUT;
   logic [DW-1:0]   SNK_DIN;
   logic [IW-1:0]   SNK_ID, GNT_ID;
`ifdef FIFO_RR_SCHED_PERF_EN
   logic            PERF_CLR;
   logic [NS*16-1:0] PERF_CNT;
`endif

   fifo_rr_sched #(.DWIDTH(DW), .NSRC(NS), .BURST(BL), .IDW(IW)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .SRC_EMPTY(SRC_EMPTY), .SRC_RD_EN(SRC_RD_EN),
      .SRC_DOUT(SRC_DOUT), .SNK_FULL(SNK_FULL), .SNK_WR_EN(SNK_WR_EN),
      .SNK_DIN(SNK_DIN), .SNK_ID(SNK_ID), .GNT_ID(GNT_ID), .BUSY(BUSY)
`ifdef FIFO_RR_SCHED_PERF_EN
      , .PERF_CLR(PERF_CLR), .PERF_CNT(PERF_CNT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // source FIFO models: 1-cycle read latency
   logic [DW-1:0] mem [NS][256];
   int wr_p [NS];
   int rd_p [NS];
   logic flush;
   bit [DW-1:0] mq [NS][$];

   initial begin
      for (int i = 0; i < NS; i++) begin wr_p[i] = 0; rd_p[i] = 0; end
      SRC_DOUT = '0;
   end

   always_comb begin
      for (int i = 0; i < NS; i++) SRC_EMPTY[i] = (rd_p[i] == wr_p[i]);
   end

   always @(posedge CLK) begin
      for (int i = 0; i < NS; i++) begin
         if (flush) rd_p[i] <= wr_p[i];
         else if (SRC_RD_EN[i]) begin
            SRC_DOUT[i*DW +: DW] <= mem[i][rd_p[i] % 256];
            rd_p[i] <= rd_p[i] + 1;
         end
      end
   end

   task automatic push_word(input int s, input logic [DW-1:0] d);
      mem[s][wr_p[s] % 256] = d;
      wr_p[s] = wr_p[s] + 1;
      mq[s].push_back(d);
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NS; i++) if (rd_p[i] != wr_p[i]) return 1'b0;
      return 1'b1;
   endfunction

   // abstract scheduler: whole bursts off per-source queues, round robin
   int mptr = 0;
   bit [63:0] exp_seq [$];
   int m_gnt [$];
   int m_len [$];

   task automatic model_run();
      bit found;
      int g, n;
      exp_seq.delete(); m_gnt.delete(); m_len.delete();
      forever begin
         found = 1'b0; g = 0;
         for (int k = 0; k < NS; k++)
            if (!found && mq[(mptr + k) % NS].size() != 0) begin
               found = 1'b1; g = (mptr + k) % NS;
            end
         if (!found) break;
         n = (mq[g].size() < BL) ? mq[g].size() : BL;
         for (int k = 0; k < n; k++) exp_seq.push_back({24'd0, 8'(g), mq[g].pop_front()});
         m_gnt.push_back(g);
         m_len.push_back(n);
         mptr = (g + 1) % NS;
      end
   endtask

   // per-cycle compare: sink words against pop-ordered scoreboard, plus protocol rules
   bit [63:0] sb [$];
   bit [63:0] log_q [$];
   int log_cyc [$];
   int cyc = 0;
   int pend = 0;
   int pop_total = 0;

   always @(negedge CLK) begin
      cyc++;
      if (!RST) begin
         sb.delete();
         pend = 0;
      end else begin
         if (pend > 0) chk("busy_while_held", BUSY, 1);
         chk("rd_on_empty", |(SRC_RD_EN & SRC_EMPTY), 0);
         chk("rd_onehot", $countones(SRC_RD_EN) <= 1, 1);
         chk("wr_when_full", SNK_WR_EN & SNK_FULL, 0);
         if (SNK_WR_EN) begin
            log_q.push_back({24'd0, 8'(SNK_ID), SNK_DIN});
            log_cyc.push_back(cyc);
            chk("write_expected", sb.size() != 0, 1);
            if (sb.size() != 0) chk("sink_word", {24'd0, 8'(SNK_ID), SNK_DIN}, sb.pop_front());
            pend--;
         end
         for (int i = 0; i < NS; i++)
            if (SRC_RD_EN[i]) begin
               chk("rd_matches_gnt", 64'(i), 64'(GNT_ID));
               sb.push_back({24'd0, 8'(i), mem[i][rd_p[i] % 256]});
               pend++;
               pop_total++;
            end
         chk("held_le2", pend <= 2, 1);
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, SRC_RD_EN, 0);
      chk({tag, "_wr_en"}, SNK_WR_EN, 0);
      chk({tag, "_din"}, SNK_DIN, 0);
      chk({tag, "_id"}, SNK_ID, 0);
      chk({tag, "_gnt"}, GNT_ID, 0);
      chk({tag, "_busy"}, BUSY, 0);
   endtask

   task automatic do_reset(input bit flush_src);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check_outputs_zero("reset");
      if (flush_src) flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      for (int i = 0; i < NS; i++) mq[i].delete();
      @(negedge CLK);
      RST = 1'b1;
      mptr = 0;
   endtask

   task automatic wait_done(input int budget, input bit rnd_full);
      bit done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge CLK);
         if (rnd_full) SNK_FULL = ($urandom_range(0, 2) == 0);
         if (all_empty() && !BUSY && pend == 0) done = 1'b1;
      end
      SNK_FULL = 1'b0;
      chk("done_in_budget", done, 1);
   endtask

   task automatic compare_log(input string tag);
      int n;
      chk({tag, "_count"}, log_q.size(), exp_seq.size());
      n = (log_q.size() < exp_seq.size()) ? log_q.size() : exp_seq.size();
      for (int i = 0; i < n; i++) chk({tag, "_word"}, log_q[i], exp_seq[i]);
   endtask

   int len_a [3] = '{4, 4, 2};
   int gnt_b [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int gnt_d [4] = '{1, 2, 3, 1};
   int len_d [4] = '{4, 2, 3, 2};

   initial begin
      RST = 1'b0; EN = 1'b0; SNK_FULL = 1'b0; flush = 1'b0;
`ifdef FIFO_RR_SCHED_PERF_EN
      PERF_CLR = 1'b0;
`endif
      repeat (3) @(negedge CLK);
      check_outputs_zero("por");
      RST = 1'b1;

      // A: single source, 10 words -> bursts 4,4,2
      for (int k = 0; k < 10; k++) push_word(0, 32'h1000 + 32'(k));
      model_run();
      chk("A_model_nbursts", m_len.size(), 3);
      for (int i = 0; i < 3 && i < m_len.size(); i++) chk("A_model_len", m_len[i], len_a[i]);
      log_q.delete(); log_cyc.delete();
      EN = 1'b1;
      wait_done(200, 1'b0);
      compare_log("A");
      chk("A_log_len", log_cyc.size() >= 5, 1);
      if (log_cyc.size() >= 5) begin
         chk("A_back_to_back", log_cyc[1] - log_cyc[0], 1);
         chk("A_grant_gap", log_cyc[4] - log_cyc[3], 3);
      end
      EN = 1'b0;

      // B: four sources, 8 words each
      do_reset(1'b0);
      for (int s = 0; s < NS; s++)
         for (int k = 0; k < 8; k++) push_word(s, 32'h0A0 + 32'(s * 16 + k));
      model_run();
      chk("B_model_ngrants", m_gnt.size(), 8);
      for (int i = 0; i < 8 && i < m_gnt.size(); i++) chk("B_model_gnt", m_gnt[i], gnt_b[i]);
      log_q.delete(); log_cyc.delete();
      EN = 1'b1;
      wait_done(300, 1'b0);
      compare_log("B");
      EN = 1'b0;

      // C: sink full for 20 cycles mid-burst
      do_reset(1'b0);
      for (int k = 0; k < 8; k++) push_word(1, 32'hC000 + 32'(k));
      model_run();
      log_q.delete(); log_cyc.delete();
      EN = 1'b1;
      for (int c = 0; c < 100 && log_q.size() < 2; c++) @(negedge CLK);
      chk("C_reached_two", log_q.size() >= 2, 1);
      SNK_FULL = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         chk("C_no_write_full", SNK_WR_EN, 0);
      end
      chk("C_held_two", pend, 2);
      SNK_FULL = 1'b0;
      wait_done(200, 1'b0);
      compare_log("C");
      EN = 1'b0;

      // D: source 2 runs dry mid-burst, pointer moves to 3
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) push_word(1, 32'hD100 + 32'(k));
      for (int k = 0; k < 2; k++) push_word(2, 32'hD200 + 32'(k));
      for (int k = 0; k < 3; k++) push_word(3, 32'hD300 + 32'(k));
      model_run();
      chk("D_model_ngrants", m_gnt.size(), 4);
      for (int i = 0; i < 4 && i < m_gnt.size(); i++) begin
         chk("D_model_gnt", m_gnt[i], gnt_d[i]);
         chk("D_model_len", m_len[i], len_d[i]);
      end
      log_q.delete(); log_cyc.delete();
      EN = 1'b1;
      wait_done(200, 1'b0);
      compare_log("D");
      EN = 1'b0;

      // E: EN dropped mid-burst, then reset mid-burst
      do_reset(1'b0);
      begin
         int p0;
         for (int k = 0; k < 8; k++) push_word(1, 32'hE000 + 32'(k));
         p0 = pop_total;
         EN = 1'b1;
         for (int c = 0; c < 50 && pop_total < p0 + 2; c++) @(negedge CLK);
         chk("E_popped_two", pop_total >= p0 + 2, 1);
         EN = 1'b0;
         #1;
         chk("E_rd_stops", SRC_RD_EN, 0);
         for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            chk("E_no_pop_en_low", SRC_RD_EN, 0);
         end
         chk("E_busy_fell", BUSY, 0);
         chk("E_pending_delivered", pend, 0);
         p0 = pop_total;
         EN = 1'b1;
         for (int c = 0; c < 50 && pop_total < p0 + 2; c++) @(negedge CLK);
         chk("E_resumed", pop_total >= p0 + 2, 1);
         do_reset(1'b1);
         EN = 1'b0;
      end

      // R: random loads with random sink back-pressure
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < NS; s++) begin
            int n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) push_word(s, $urandom);
         end
         model_run();
         log_q.delete(); log_cyc.delete();
         EN = 1'b1;
         wait_done(800, 1'b1);
         compare_log("R");
         EN = 1'b0;
      end

`ifdef FIFO_RR_SCHED_PERF_EN
      do_reset(1'b0);
      for (int k = 0; k < 5; k++) push_word(1, 32'hF100 + 32'(k));
      for (int k = 0; k < 3; k++) push_word(3, 32'hF300 + 32'(k));
      model_run();
      log_q.delete(); log_cyc.delete();
      EN = 1'b1;
      wait_done(200, 1'b0);
      compare_log("P");
      chk("P_cnt0", PERF_CNT[0 +: 16], 0);
      chk("P_cnt1", PERF_CNT[16 +: 16], 5);
      chk("P_cnt2", PERF_CNT[32 +: 16], 0);
      chk("P_cnt3", PERF_CNT[48 +: 16], 3);
      PERF_CLR = 1'b1;
      @(negedge CLK);
      PERF_CLR = 1'b0;
      chk("P_cleared", PERF_CNT, 0);
      EN = 1'b0;
`endif

      repeat (3) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
